// File: rtl/resize_pkg.sv
// Shared FSM encoding and FP16 constants for the 2x horizontal resize controller.
package resize_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ROW_RD,
      ROW_LD,
      EVEN,
      ODD,
      DRAIN,
      DONE
   } state_t;

   localparam logic [15:0] FP16_ZERO      = 16'h0000;
   localparam logic [15:0] FP16_HALF      = 16'h3800;
   localparam int          DP_LAT_DEFAULT = 3;

endpackage

// File: rtl/resize_if.sv
// Source-read, datapath and destination-write bus of the resize controller.
interface resize_if #(
   parameter int DW = 16,
   parameter int AW = 16
);

   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;

   logic          dp_enable;
   logic [DW-1:0] dp_data_in1;
   logic [DW-1:0] dp_data_in2;
   logic [DW-1:0] dp_scale;
   logic [DW-1:0] dp_data_out;

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ready;

   modport master (
      output rd_en, rd_addr,
      output dp_enable, dp_data_in1, dp_data_in2, dp_scale,
      output wr_en, wr_addr, wr_data,
      input  rd_data, dp_data_out, wr_ready
   );

   modport slave (
      input  rd_en, rd_addr,
      input  dp_enable, dp_data_in1, dp_data_in2, dp_scale,
      input  wr_en, wr_addr, wr_data,
      output rd_data, dp_data_out, wr_ready
   );

endinterface

// File: rtl/resize_tag_pipe.sv
// Valid+address shift register tracking ops in flight through the external datapath.
module resize_tag_pipe #(
   parameter int AW    = 16,
   parameter int DEPTH = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          push_valid,
   input  logic [AW-1:0] push_addr,
   output logic          head_valid,
   output logic [AW-1:0] head_addr,
   output logic          body_empty
);

   logic [DEPTH-1:0] valid_q;
   logic [AW-1:0]    addr_q [DEPTH];

   // NOTE: the address stages are reset too so wr_addr reads 0 out of reset;
   // this is a short shift register, not a RAM, so the reset costs nothing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
      end else if (en) begin
         valid_q[0] <= push_valid;
         addr_q[0]  <= push_addr;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            addr_q[i]  <= addr_q[i-1];
         end
      end
   end

   assign head_valid = valid_q[DEPTH-1];
   assign head_addr  = addr_q[DEPTH-1];

   // Empty behind the head: once the head retires, nothing is left in flight.
   always_comb begin
      body_empty = 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (valid_q[i]) body_empty = 1'b0;
      end
   end

endmodule

// File: rtl/resize_ctrl.sv
// Horizontal 2x linear upsampler controller: streams source rows, drives the
// external lerp datapath and writes 2W x H results through a tag pipeline.
module resize_ctrl
   import resize_pkg::*;
#(
   parameter int DW     = 16,
   parameter int AW     = 16,
   parameter int DP_LAT = DP_LAT_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [7:0]    cfg_width,
   input  logic [7:0]    cfg_height,
   input  logic [AW-1:0] cfg_base_in,
   input  logic [AW-1:0] cfg_base_out,
   output logic          busy,
   output logic          done,
   resize_if.master      bus
);

   state_t        state, state_nx;
   logic [7:0]    w_q, h_q, k_q, row_q;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [DW-1:0] cur_q;
   logic          done_q;

   logic          head_valid, body_empty;
   logic [AW-1:0] head_addr;
   logic          stall, accept, last_col, last_row;
   logic          rd_req, issue;
   logic [DW-1:0] odd_in2, op_in1, op_in2, op_scale;

   assign stall    = head_valid & ~bus.wr_ready;
   assign busy     = (state != IDLE) | done_q;
   assign done     = done_q;
   assign accept   = (state == IDLE) & ~done_q & start;
   assign last_col = (k_q == w_q - 8'd1);
   assign last_row = (row_q == h_q - 8'd1);
   // At the row end the neighbour is the edge pixel itself; no read was issued for it.
   assign odd_in2  = last_col ? cur_q : bus.rd_data;

   // NOTE: flops use non-blocking assignments so every register samples the
   // pre-edge value of every other register regardless of process order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      rd_req   = 1'b0;
      issue    = 1'b0;
      op_in1   = '0;
      op_in2   = '0;
      op_scale = '0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nx = (cfg_width == 8'd0 || cfg_height == 8'd0) ? DONE : ROW_RD;
            end
         end
         ROW_RD: begin
            rd_req   = 1'b1;
            state_nx = ROW_LD;
         end
         ROW_LD: state_nx = EVEN;
         EVEN: begin
            issue    = 1'b1;
            op_in1   = cur_q;
            op_in2   = cur_q;
            op_scale = DW'(FP16_ZERO);
            rd_req   = ~last_col;
            state_nx = ODD;
         end
         ODD: begin
            issue    = 1'b1;
            op_in1   = cur_q;
            op_in2   = odd_in2;
            op_scale = DW'(FP16_HALF);
            if (!last_col)      state_nx = EVEN;
            else if (!last_row) state_nx = ROW_RD;
            else                state_nx = DRAIN;
         end
         DRAIN: begin
            if (body_empty) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      // A blocked write freezes the whole job, including the read port.
      if (stall) begin
         state_nx = state;
         rd_req   = 1'b0;
         issue    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_q    <= '0;
         h_q    <= '0;
         k_q    <= '0;
         row_q  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         cur_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state == DONE);
         if (accept) begin
            w_q    <= cfg_width;
            h_q    <= cfg_height;
            k_q    <= '0;
            row_q  <= '0;
            rd_ptr <= cfg_base_in;
            wr_ptr <= cfg_base_out;
         end else if (!stall) begin
            // Source and destination are both visited in raster order, so plain
            // incrementing pointers replace r*W+k and r*2W+j arithmetic.
            if (rd_req) rd_ptr <= rd_ptr + AW'(1);
            if (issue)  wr_ptr <= wr_ptr + AW'(1);
            if (state == ROW_LD) cur_q <= bus.rd_data;
            if (state == ODD) begin
               cur_q <= odd_in2;
               if (last_col) begin
                  k_q   <= '0;
                  row_q <= row_q + 8'd1;
               end else begin
                  k_q <= k_q + 8'd1;
               end
            end
         end
      end
   end

   resize_tag_pipe #(
      .AW    (AW),
      .DEPTH (DP_LAT)
   ) u_tag_pipe (
      .clk        (clk),
      .reset      (reset),
      .en         (bus.dp_enable),
      .push_valid (issue),
      .push_addr  (wr_ptr),
      .head_valid (head_valid),
      .head_addr  (head_addr),
      .body_empty (body_empty)
   );

   assign bus.rd_en       = rd_req;
   assign bus.rd_addr     = rd_ptr;
   assign bus.dp_enable   = busy & ~stall;
   assign bus.dp_data_in1 = op_in1;
   assign bus.dp_data_in2 = op_in2;
   assign bus.dp_scale    = op_scale;
   assign bus.wr_en       = head_valid & bus.wr_ready;
   assign bus.wr_addr     = head_addr;
   assign bus.wr_data     = head_valid ? bus.dp_data_out : '0;

endmodule

// File: tb/tb_resize_ctrl.sv
// Randomized self-checking bench for resize_ctrl with a behavioural lerp datapath,
// source memory and write sink; expectations come from a raster-order reference model.
module tb_resize_ctrl;
   import resize_pkg::*;

   localparam int DW     = 16;
   localparam int AW     = 16;
   localparam int DP_LAT = DP_LAT_DEFAULT;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    cfg_width = '0;
   logic [7:0]    cfg_height = '0;
   logic [AW-1:0] cfg_base_in = '0;
   logic [AW-1:0] cfg_base_out = '0;
   logic          busy, done;

   resize_if #(.DW(DW), .AW(AW)) bus ();

   resize_ctrl #(.DW(DW), .AW(AW), .DP_LAT(DP_LAT)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .cfg_width    (cfg_width),
      .cfg_height   (cfg_height),
      .cfg_base_in  (cfg_base_in),
      .cfg_base_out (cfg_base_out),
      .busy         (busy),
      .done         (done),
      .bus          (bus.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] src_mem [2**AW];
   logic [DW-1:0] dp_pipe [DP_LAT];

   logic [AW-1:0] exp_addr[$], obs_addr[$];
   logic [DW-1:0] exp_data[$], obs_data[$];
   int rd_cnt, stall_cnt, first_stall, done_cnt, done_t, exp_done_t;
   logic busy_at_done, busy_after;

   // ---------------- FP16 helpers (positive normals only) ----------------
   function automatic real h2r(input logic [15:0] h);
      int  e;
      real r;
      e = int'(h[14:10]);
      if (e == 0) return 0.0;
      r = 1.0 + real'(h[9:0]) / 1024.0;
      for (int i = e; i < 15; i++) r = r / 2.0;
      for (int i = 15; i < e; i++) r = r * 2.0;
      return r;
   endfunction

   function automatic logic [15:0] r2h(input real r);
      int          e, m;
      logic [15:0] h;
      if (r <= 0.0) return 16'h0000;
      e = 15;
      while (r >= 2.0) begin r = r / 2.0; e++; end
      while (r < 1.0)  begin r = r * 2.0; e--; end
      m = $rtoi((r - 1.0) * 1024.0 + 0.5);
      if (m >= 1024) begin m = 0; e++; end
      h = {1'b0, e[4:0], m[9:0]};
      return h;
   endfunction

   // Datapath contract: in1 + scale * (in2 - in1).
   function automatic logic [15:0] lerp(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] s);
      real ra, rb;
      ra = h2r(a);
      rb = h2r(b);
      return r2h(ra + h2r(s) * (rb - ra));
   endfunction

   // Pixels in [1.0, 2.0) with an even mantissa keep every midpoint exact.
   function automatic logic [15:0] rand_pixel();
      return 16'h3C00 | 16'($urandom & 32'h3FE);
   endfunction

   // ---------------- behavioural environment ----------------
   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= src_mem[bus.rd_addr];
   end

   always @(posedge clk) begin
      if (bus.dp_enable) begin
         dp_pipe[0] <= lerp(bus.dp_data_in1, bus.dp_data_in2, bus.dp_scale);
         for (int i = 1; i < DP_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
      end
   end
   assign bus.dp_data_out = dp_pipe[DP_LAT-1];

   // ---------------- checking ----------------
   task automatic check(input string tag, input longint got, input longint want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
      end
   endtask

   task automatic clear_obs();
      obs_addr.delete();
      obs_data.delete();
      rd_cnt      = 0;
      stall_cnt   = 0;
      first_stall = -1;
      done_cnt    = 0;
      done_t      = -1;
      busy_at_done = 1'b0;
      busy_after   = 1'b1;
   endtask

   // Called once per cycle at the falling edge.
   task automatic sample(input int t);
      if (bus.wr_en) begin
         obs_addr.push_back(bus.wr_addr);
         obs_data.push_back(bus.wr_data);
      end
      if (bus.rd_en) rd_cnt++;
      if (busy && !bus.dp_enable) begin
         stall_cnt++;
         if (first_stall < 0) first_stall = t;
      end
      if (done) begin
         done_cnt++;
         if (done_t < 0) done_t = t;
      end
      if (t == exp_done_t)     busy_at_done = busy;
      if (t == exp_done_t + 1) busy_after   = busy;
   endtask

   task automatic run_job(input int w, input int h, input logic [AW-1:0] bin,
                          input logic [AW-1:0] bout, input int stall_len,
                          input bit rand_pix, input bit dup_start, input string name);
      logic [AW-1:0] a;
      logic [DW-1:0] p, pn;
      int            first_wr;
      exp_addr.delete();
      exp_data.delete();
      clear_obs();
      if (rand_pix) begin
         for (int i = 0; i < w * h; i++) src_mem[AW'(int'(bin) + i)] = rand_pixel();
      end
      for (int r = 0; r < h; r++) begin
         for (int k = 0; k < w; k++) begin
            p  = src_mem[AW'(int'(bin) + r * w + k)];
            pn = (k < w - 1) ? src_mem[AW'(int'(bin) + r * w + k + 1)] : p;
            a  = AW'(int'(bout) + r * 2 * w + 2 * k);
            exp_addr.push_back(a);
            exp_data.push_back(lerp(p, p, FP16_ZERO));
            exp_addr.push_back(a + AW'(1));
            exp_data.push_back(lerp(p, pn, FP16_HALF));
         end
      end
      exp_done_t = (w == 0 || h == 0) ? 2 : 1 + h * (2 + 2 * w) + DP_LAT + 1 + stall_len;
      first_wr   = 3 + DP_LAT;

      @(posedge clk); #1;
      start        = 1'b1;
      cfg_width    = 8'(w);
      cfg_height   = 8'(h);
      cfg_base_in  = bin;
      cfg_base_out = bout;
      bus.wr_ready = 1'b1;
      @(negedge clk);
      sample(0);
      for (int t = 1; t <= exp_done_t + 4; t++) begin
         @(posedge clk); #1;
         start = dup_start && (t == 4 || t == exp_done_t);
         if (t == 1) begin
            cfg_width   = 8'($urandom);
            cfg_height  = 8'($urandom);
            cfg_base_in = AW'($urandom);
         end
         bus.wr_ready = !(stall_len > 0 && t >= first_wr && t < first_wr + stall_len);
         @(negedge clk);
         sample(t);
      end
      start        = 1'b0;
      bus.wr_ready = 1'b1;

      check({name, ":done_time"}, done_t, exp_done_t);
      check({name, ":done_pulses"}, done_cnt, 1);
      check({name, ":busy_in_done"}, busy_at_done, 1);
      check({name, ":busy_after"}, busy_after, 0);
      check({name, ":reads"}, rd_cnt, w * h);
      check({name, ":dp_off_cycles"}, stall_cnt, stall_len);
      if (stall_len > 0) check({name, ":first_stall"}, first_stall, first_wr);
      check({name, ":writes"}, obs_addr.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size(); i++) begin
         check({name, ":wr_addr"}, (i < obs_addr.size()) ? obs_addr[i] : 'x, exp_addr[i]);
         check({name, ":wr_data"}, (i < obs_data.size()) ? obs_data[i] : 'x, exp_data[i]);
      end
   endtask

   task automatic check_fixed_w2h1(input string name);
      logic [15:0] want_addr [4];
      logic [15:0] want_data [4];
      want_addr = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
      want_data = '{16'h3C00, 16'h3E00, 16'h4000, 16'h4000};
      for (int i = 0; i < 4; i++) begin
         check({name, ":const_addr"}, (i < obs_addr.size()) ? obs_addr[i] : 'x, want_addr[i]);
         check({name, ":const_data"}, (i < obs_data.size()) ? obs_data[i] : 'x, want_data[i]);
      end
   endtask

   task automatic reset_test();
      clear_obs();
      exp_done_t = -10;
      for (int i = 0; i < 8; i++) src_mem[16'h0200 + 16'(i)] = rand_pixel();
      @(posedge clk); #1;
      start = 1'b1; cfg_width = 8'd4; cfg_height = 8'd2;
      cfg_base_in = 16'h0200; cfg_base_out = 16'h0400;
      @(negedge clk);
      sample(0);
      for (int t = 1; t < 8; t++) begin
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         sample(t);
      end
      check("rst:writes_before", obs_addr.size(), 2);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst:busy", busy, 0);
      check("rst:done", done, 0);
      check("rst:ctl_en", {bus.rd_en, bus.wr_en, bus.dp_enable}, 3'b000);
      check("rst:addrs", {bus.rd_addr, bus.wr_addr}, 0);
      check("rst:data", {bus.wr_data, bus.dp_data_in1, bus.dp_data_in2, bus.dp_scale}, 0);
      clear_obs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         sample(t);
      end
      check("rst:writes_after", obs_addr.size(), 0);
      check("rst:done_after", done_cnt, 0);
      check("rst:reads_after", rd_cnt, 0);
   endtask

   initial begin
      bus.wr_ready = 1'b1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("por:busy", busy, 0);
      check("por:done", done, 0);
      check("por:ctl_en", {bus.rd_en, bus.wr_en, bus.dp_enable}, 3'b000);
      check("por:wr_data", bus.wr_data, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      src_mem[16'h0010] = 16'h3C00;
      src_mem[16'h0011] = 16'h4000;
      run_job(2, 1, 16'h0010, 16'h0100, 0, 1'b0, 1'b0, "w2h1");
      check_fixed_w2h1("w2h1");

      run_job(3, 2, 16'h0020, 16'h0300, 0, 1'b1, 1'b0, "w3h2");

      run_job(2, 1, 16'h0010, 16'h0100, 5, 1'b0, 1'b0, "stall5");
      check_fixed_w2h1("stall5");

      run_job(0, 3, 16'h0040, 16'h0500, 0, 1'b1, 1'b0, "w0");
      run_job(5, 0, 16'h0040, 16'h0500, 0, 1'b1, 1'b0, "h0");

      run_job(3, 1, 16'h0060, 16'h0600, 0, 1'b1, 1'b1, "dup_start");

      run_job(3, 2, 16'hFFFE, 16'hFFF8, 0, 1'b1, 1'b0, "wrap");

      for (int j = 0; j < 4; j++) begin
         run_job(int'($urandom_range(1, 6)), int'($urandom_range(1, 3)),
                 AW'($urandom), AW'($urandom), int'($urandom_range(0, 3)),
                 1'b1, 1'b0, "rand");
      end

      reset_test();
      run_job(4, 2, 16'h0700, 16'h0800, 0, 1'b1, 1'b0, "post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/resize_ctrl.md
RESIZE_CTRL -- requirements
Module: resize_ctrl

Interface
REQ-001 Parameter DW, default 16, pixel width (FP16).
REQ-002 Parameter AW, default 16, memory address width.
REQ-003 Parameter DP_LAT, default 3, resize_datapath latency in enabled cycles.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle job request; ignored while busy=1.
REQ-007 cfg_width, cfg_height  in  8 each  input map size in pixels, sampled on accepted start.
REQ-008 cfg_base_in, cfg_base_out  in  AW each  source and destination base addresses, sampled on accepted start.
REQ-009 busy  out  1  high from the cycle after an accepted start through the done cycle.
REQ-010 done  out  1  one-cycle job-complete pulse.
REQ-011 rd_en, rd_addr  out  1/AW  source read request; rd_data  in  DW  valid 1 cycle after rd_en and held until the next rd_en.
REQ-012 dp_enable, dp_data_in1, dp_data_in2, dp_scale  out  1/DW/DW/DW  datapath drive; dp_data_out  in  DW  datapath result.
REQ-013 wr_en, wr_addr, wr_data  out  1/AW/DW  destination write; wr_ready  in  1  sink accepts a write this cycle.

Function
REQ-014 The block performs horizontal 2x linear upsampling: each row of W input pixels produces 2W outputs; the output map is 2W x H.
REQ-015 Datapath contract: dp_data_out = in1 + scale*(in2-in1), DP_LAT enabled cycles after issue.
REQ-016 For source pixel k of row r, the block issues two ops:
- even op: (p[k], p[k], FP16 0.0 = 16'h0000) -> out addr base_out + r*2W + 2k
- odd op: (p[k], p[k+1], FP16 0.5 = 16'h3800) -> out addr base_out + r*2W + 2k+1
REQ-017 Right edge: for k = W-1 the odd op uses in2 = p[W-1]; no read is issued past the row end.
REQ-018 Source read address is base_in + r*W + k; addresses come from running counters, not multipliers, and wrap modulo 2^AW.
REQ-019 FSM states: IDLE, ROW_RD, ROW_LD, EVEN, ODD, DRAIN, DONE.
REQ-020 Transitions:
- IDLE -> ROW_RD on start, or -> DONE if W=0 or H=0.
- ROW_RD reads p[0] -> ROW_LD.
- ROW_LD latches cur <= rd_data -> EVEN.
- EVEN issues the even op and reads p[k+1] if k < W-1 -> ODD.
- ODD issues the odd op, sets cur <= in2, then -> EVEN (k++), or -> ROW_RD (next row, k=0), or -> DRAIN after the last row.
- DRAIN -> DONE when the tag pipeline is empty.
- DONE pulses done -> IDLE.
REQ-021 Each issue cycle pushes {valid=1, out_addr} into a DP_LAT-deep tag pipeline; every non-issue enabled cycle pushes a bubble.
REQ-022 Pipeline head valid: wr_en = wr_ready, wr_addr = head addr, wr_data = dp_data_out.
REQ-023 Stall = head valid & !wr_ready. While stalled: dp_enable=0, tag pipeline frozen, FSM frozen, rd_en=0.
REQ-024 Without stall, dp_enable=1 whenever busy; an op issued in cycle t is written in cycle t+DP_LAT.
REQ-025 Unstalled job time from start: 1 + H*(2+2W) cycles of issue, then DP_LAT drain, then the done cycle.
REQ-026 With W=0 or H=0: done pulses 2 cycles after start and no rd_en or wr_en occurs.
REQ-027 start asserted in the done cycle or while busy is ignored.

Reset
REQ-028 Reset forces state IDLE and clears busy, done, rd_en, wr_en, dp_enable, all tag valids, and all counters to 0; data outputs go to 0.
REQ-029 Reset mid-job aborts the job immediately; no write occurs after reset asserts, and done is not pulsed.

Structure
REQ-030 Shared package resize_pkg holds the FSM state enum, FP16_ZERO=16'h0000, FP16_HALF=16'h3800, and the default DP_LAT.
REQ-031 The tag pipeline is a sub-module resize_tag_pipe (valid+address shift register with enable); the datapath stays external.

Verification
REQ-032 W=2, H=1, base_in=0x0010, base_out=0x0100, pixels {1.0=3C00, 2.0=4000}, wr_ready=1 -> writes 0x100:3C00, 0x101:3E00, 0x102:4000, 0x103:4000; done 1+6+3+1 cycles after start.
REQ-033 W=3, H=2 -> 12 writes at contiguous addresses base_out..base_out+11, exactly 6 rd_en pulses, busy low after done.
REQ-034 W=2, H=1 with wr_ready=0 for 5 cycles at the first write -> dp_enable low exactly those 5 cycles, output values and order unchanged, done delayed by 5.
REQ-035 cfg_width=0 -> done 2 cycles after start, zero reads and zero writes.
REQ-036 Reset asserted mid-row of a W=4, H=2 job -> all outputs 0 next cycle and no further writes; a new start then completes a correct job.
REQ-037 start pulsed again while busy -> ignored; exactly one done pulse and no duplicate writes.
